// File: rtl/cpu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// Module   : cpu_ctrl_pkg
// Purpose  : Shared opcode map, MDR source encodings, sequencer state type
//            and strobe bundle for the hardwired control unit.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package cpu_ctrl_pkg;

  localparam int MAX_STEP = 7;
  localparam int STEP_W   = 3;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_JAL  = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10101;
  localparam logic [4:0] OP_OUT  = 5'b10110;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  localparam logic [2:0] MDR_IDLE = 3'b000;
  localparam logic [2:0] MDR_BUS  = 3'b001;
  localparam logic [2:0] MDR_RAM  = 3'b010;
  localparam logic [2:0] MDR_MDIN = 3'b100;

  typedef enum logic [2:0] {
    FETCH0 = 3'd0,
    FETCH1 = 3'd1,
    FETCH2 = 3'd2,
    EXEC   = 3'd3,
    HALT   = 3'd4
  } ctrl_state_t;

  typedef struct packed {
    logic       pc_out;
    logic       zlow_out;
    logic       zhigh_out;
    logic       mdr_out;
    logic       hi_out;
    logic       lo_out;
    logic       inport_out;
    logic       c_out;
    logic       en_mar;
    logic       en_mdr;
    logic       en_ir;
    logic       en_y;
    logic       en_z;
    logic       en_pc;
    logic       en_hi;
    logic       en_lo;
    logic       en_con;
    logic       en_outport;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       r_enable;
    logic       r_out;
    logic       ba_out;
    logic       r_enable_in15;
    logic       inc_pc;
    logic       ram_read;
    logic       ram_write;
    logic [2:0] mdr_read;
  } strobes_t;

  // Final T-state index of each instruction; unknown opcodes behave as nop.
  function automatic logic [STEP_W-1:0] last_step(input logic [4:0] op);
    case (op)
      OP_LD, OP_ST:                               return STEP_W'(MAX_STEP);
      OP_LDI, OP_ADD, OP_SUB, OP_SHR, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR,
      OP_ADDI, OP_ANDI, OP_ORI:                   return 3'd5;
      OP_MUL, OP_DIV, OP_BR:                      return 3'd6;
      OP_NEG, OP_NOT, OP_JAL:                     return 3'd4;
      OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO,
      OP_NOP, OP_HALT:                            return 3'd3;
      default:                                    return 3'd3;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_step_decode.sv
// ---------------------------------------------------------------------------
// Module   : ctrl_step_decode
// Purpose  : Pure combinational map from (state, T-step, latched opcode,
//            branch flag) to the full control-strobe bundle.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module ctrl_step_decode
  import cpu_ctrl_pkg::*;
(
  input  ctrl_state_t       state,
  input  logic [STEP_W-1:0] step,
  input  logic [4:0]        op,
  input  logic              con,
  output strobes_t          strobes
);

  // Strobe decode: everything defaults low, each T-state raises its own set.
  always_comb begin
    strobes          = '0;
    strobes.mdr_read = MDR_IDLE;
    case (state)
      FETCH0: begin
        strobes.pc_out = 1'b1; strobes.inc_pc = 1'b1;
        strobes.en_mar = 1'b1; strobes.en_z   = 1'b1;
      end
      FETCH1: begin
        strobes.zlow_out = 1'b1; strobes.en_pc    = 1'b1;
        strobes.ram_read = 1'b1; strobes.mdr_read = MDR_RAM;
        strobes.en_mdr   = 1'b1;
      end
      FETCH2: begin
        strobes.mdr_out = 1'b1; strobes.en_ir = 1'b1;
      end
      EXEC: begin
        case (op)
          OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR: begin
            case (step)
              3'd3: begin strobes.grb = 1'b1; strobes.r_out = 1'b1; strobes.en_y = 1'b1; end
              3'd4: begin strobes.grc = 1'b1; strobes.r_out = 1'b1; strobes.en_z = 1'b1; end
              3'd5: begin strobes.zlow_out = 1'b1; strobes.gra = 1'b1; strobes.r_enable = 1'b1; end
              default: ;
            endcase
          end
          OP_ADDI, OP_ANDI, OP_ORI: begin
            case (step)
              3'd3: begin strobes.grb = 1'b1; strobes.r_out = 1'b1; strobes.en_y = 1'b1; end
              3'd4: begin strobes.c_out = 1'b1; strobes.en_z = 1'b1; end
              3'd5: begin strobes.zlow_out = 1'b1; strobes.gra = 1'b1; strobes.r_enable = 1'b1; end
              default: ;
            endcase
          end
          OP_MUL, OP_DIV: begin
            case (step)
              3'd3: begin strobes.gra = 1'b1; strobes.r_out = 1'b1; strobes.en_y = 1'b1; end
              3'd4: begin strobes.grb = 1'b1; strobes.r_out = 1'b1; strobes.en_z = 1'b1; end
              3'd5: begin strobes.zlow_out = 1'b1; strobes.en_lo = 1'b1; end
              3'd6: begin strobes.zhigh_out = 1'b1; strobes.en_hi = 1'b1; end
              default: ;
            endcase
          end
          OP_NEG, OP_NOT: begin
            case (step)
              3'd3: begin strobes.grb = 1'b1; strobes.r_out = 1'b1; strobes.en_z = 1'b1; end
              3'd4: begin strobes.zlow_out = 1'b1; strobes.gra = 1'b1; strobes.r_enable = 1'b1; end
              default: ;
            endcase
          end
          // ld, ldi and st share the base+offset address computation in T3-T4.
          OP_LD, OP_LDI, OP_ST: begin
            case (step)
              3'd3: begin strobes.grb = 1'b1; strobes.ba_out = 1'b1; strobes.en_y = 1'b1; end
              3'd4: begin strobes.c_out = 1'b1; strobes.en_z = 1'b1; end
              3'd5: begin
                strobes.zlow_out = 1'b1;
                if (op == OP_LDI) begin
                  strobes.gra = 1'b1; strobes.r_enable = 1'b1;
                end else begin
                  strobes.en_mar = 1'b1;
                end
              end
              3'd6: begin
                if (op == OP_LD) begin
                  strobes.ram_read = 1'b1; strobes.mdr_read = MDR_RAM; strobes.en_mdr = 1'b1;
                end else if (op == OP_ST) begin
                  strobes.gra = 1'b1; strobes.r_out = 1'b1;
                  strobes.mdr_read = MDR_BUS; strobes.en_mdr = 1'b1;
                end
              end
              3'd7: begin
                if (op == OP_LD) begin
                  strobes.mdr_out = 1'b1; strobes.gra = 1'b1; strobes.r_enable = 1'b1;
                end else if (op == OP_ST) begin
                  strobes.ram_write = 1'b1;
                end
              end
              default: ;
            endcase
          end
          OP_BR: begin
            case (step)
              3'd3: begin strobes.gra = 1'b1; strobes.r_out = 1'b1; strobes.en_con = 1'b1; end
              3'd4: begin strobes.pc_out = 1'b1; strobes.en_y = 1'b1; end
              3'd5: begin strobes.c_out = 1'b1; strobes.en_z = 1'b1; end
              // The branch is taken by qualifying the PC load with the live flag.
              3'd6: begin strobes.zlow_out = 1'b1; strobes.en_pc = con; end
              default: ;
            endcase
          end
          OP_JR: begin
            if (step == 3'd3) begin
              strobes.gra = 1'b1; strobes.r_out = 1'b1; strobes.en_pc = 1'b1;
            end
          end
          OP_JAL: begin
            case (step)
              3'd3: begin strobes.pc_out = 1'b1; strobes.r_enable_in15 = 1'b1; end
              3'd4: begin strobes.gra = 1'b1; strobes.r_out = 1'b1; strobes.en_pc = 1'b1; end
              default: ;
            endcase
          end
          OP_IN, OP_MFHI, OP_MFLO: begin
            if (step == 3'd3) begin
              strobes.inport_out = (op == OP_IN);
              strobes.hi_out     = (op == OP_MFHI);
              strobes.lo_out     = (op == OP_MFLO);
              strobes.gra        = 1'b1;
              strobes.r_enable   = 1'b1;
            end
          end
          OP_OUT: begin
            if (step == 3'd3) begin
              strobes.gra = 1'b1; strobes.r_out = 1'b1; strobes.en_outport = 1'b1;
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// Module   : control_sequencer
// Purpose  : Hardwired T-state sequencer driving the 32-bit bus datapath's
//            control strobes; holds the Run/halt status.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [4:0]  opcode,
  input  logic        CON_out,
  input  logic        Stop,
  output logic        Run,
  output logic        PCout,
  output logic        ZLowout,
  output logic        ZHighout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        InPortout,
  output logic        Cout,
  output logic        enableMAR,
  output logic        enableMDR,
  output logic        enableIR,
  output logic        enableY,
  output logic        enableZ,
  output logic        enablePC,
  output logic        enableHI,
  output logic        enableLO,
  output logic        enableCON,
  output logic        enableOutPort,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        R_enable,
  output logic        Rout,
  output logic        BAout,
  output logic [15:0] R_enableIn,
  output logic        IncPC,
  output logic        RAM_read,
  output logic        RAM_write,
  output logic [2:0]  MDR_read
);

  ctrl_state_t       state, next_state;
  logic [STEP_W-1:0] step, next_step;
  logic [4:0]        op_latched;
  strobes_t          decoded, strobes;

  // State, T-step, opcode latch and Run status registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= FETCH0;
      step       <= '0;
      op_latched <= '0;
      Run        <= 1'b1;
    end else begin
      state <= next_state;
      step  <= next_step;
      if (state == FETCH2) op_latched <= opcode;
      Run   <= (next_state != HALT);
    end
  end

  // Next-state logic: fetch walks T0..T2, execute runs to the opcode's last step.
  always_comb begin
    next_state = state;
    next_step  = step;
    case (state)
      FETCH0: begin next_state = FETCH1; next_step = 3'd1; end
      FETCH1: begin next_state = FETCH2; next_step = 3'd2; end
      FETCH2: begin
        next_step  = 3'd3;
        next_state = (opcode == OP_HALT) ? HALT : EXEC;
      end
      EXEC: begin
        if (step >= last_step(op_latched)) begin
          next_step  = '0;
          next_state = Stop ? HALT : FETCH0;
        end else begin
          next_step = step + STEP_W'(1);
        end
      end
      HALT:    next_state = HALT;
      default: begin next_state = FETCH0; next_step = '0; end
    endcase
  end

  ctrl_step_decode u_decode (
    .state   (state),
    .step    (step),
    .op      (op_latched),
    .con     (CON_out),
    .strobes (decoded)
  );

  // Strobes are forced quiet while clr is held so nothing fires during reset.
  assign strobes = clr ? '0 : decoded;

  assign PCout         = strobes.pc_out;
  assign ZLowout       = strobes.zlow_out;
  assign ZHighout      = strobes.zhigh_out;
  assign MDRout        = strobes.mdr_out;
  assign HIout         = strobes.hi_out;
  assign LOout         = strobes.lo_out;
  assign InPortout     = strobes.inport_out;
  assign Cout          = strobes.c_out;
  assign enableMAR     = strobes.en_mar;
  assign enableMDR     = strobes.en_mdr;
  assign enableIR      = strobes.en_ir;
  assign enableY       = strobes.en_y;
  assign enableZ       = strobes.en_z;
  assign enablePC      = strobes.en_pc;
  assign enableHI      = strobes.en_hi;
  assign enableLO      = strobes.en_lo;
  assign enableCON     = strobes.en_con;
  assign enableOutPort = strobes.en_outport;
  assign Gra           = strobes.gra;
  assign Grb           = strobes.grb;
  assign Grc           = strobes.grc;
  assign R_enable      = strobes.r_enable;
  assign Rout          = strobes.r_out;
  assign BAout         = strobes.ba_out;
  assign R_enableIn    = {strobes.r_enable_in15, 15'b0};
  assign IncPC         = strobes.inc_pc;
  assign RAM_read      = strobes.ram_read;
  assign RAM_write     = strobes.ram_write;
  assign MDR_read      = strobes.mdr_read;

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// ---------------------------------------------------------------------------
// Module   : tb_control_sequencer
// Purpose  : Self-checking bench for control_sequencer; expected strobes come
//            from a per-instruction T-state table built in the bench.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_control_sequencer;

  typedef logic [45:0] vec_t;

  // Bit positions of the packed observation vector.
  localparam int PCO = 0,  ZL = 1,  ZH = 2,  MDRO = 3,  HIO = 4,  LOO = 5,  INO = 6,  CO = 7;
  localparam int MAR = 8,  MDR = 9, IR = 10, Y = 11,   Z = 12,   PCE = 13, HI = 14, LO = 15;
  localparam int CON = 16, OUTP = 17, GRA = 18, GRB = 19, GRC = 20, REN = 21, ROUT = 22, BA = 23;
  localparam int INC = 24, RD = 25, WR = 26, RIN15 = 42, MDR_BUS = 43, MDR_RAM = 44;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [4:0]  opcode = '0;
  logic        CON_out = 1'b0;
  logic        Stop = 1'b0;
  logic        Run;
  logic        PCout, ZLowout, ZHighout, MDRout, HIout, LOout, InPortout, Cout;
  logic        enableMAR, enableMDR, enableIR, enableY, enableZ, enablePC;
  logic        enableHI, enableLO, enableCON, enableOutPort;
  logic        Gra, Grb, Grc, R_enable, Rout, BAout;
  logic [15:0] R_enableIn;
  logic        IncPC, RAM_read, RAM_write;
  logic [2:0]  MDR_read;

  vec_t obs;
  vec_t q[$];
  int   total = 0;
  int   bad   = 0;

  control_sequencer dut (
    .clk(clk), .clr(clr), .opcode(opcode), .CON_out(CON_out), .Stop(Stop), .Run(Run),
    .PCout(PCout), .ZLowout(ZLowout), .ZHighout(ZHighout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout),
    .enableMAR(enableMAR), .enableMDR(enableMDR), .enableIR(enableIR), .enableY(enableY),
    .enableZ(enableZ), .enablePC(enablePC), .enableHI(enableHI), .enableLO(enableLO),
    .enableCON(enableCON), .enableOutPort(enableOutPort),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .R_enable(R_enable), .Rout(Rout), .BAout(BAout),
    .R_enableIn(R_enableIn), .IncPC(IncPC), .RAM_read(RAM_read), .RAM_write(RAM_write),
    .MDR_read(MDR_read)
  );

  always #5 clk = ~clk;

  assign obs = {MDR_read, R_enableIn, RAM_write, RAM_read, IncPC, BAout, Rout, R_enable,
                Grc, Grb, Gra, enableOutPort, enableCON, enableLO, enableHI, enablePC,
                enableZ, enableY, enableIR, enableMDR, enableMAR, Cout, InPortout, LOout,
                HIout, MDRout, ZHighout, ZLowout, PCout};

  function automatic vec_t b(int i);
    return vec_t'(1) << i;
  endfunction

  task automatic chk(string tag, vec_t o, vec_t e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Expected strobe set for every T-state of one instruction.
  task automatic build_q(logic [4:0] op, logic con);
    int o;
    o = int'(op);
    q = {};
    q.push_back(b(PCO) | b(INC) | b(MAR) | b(Z));
    q.push_back(b(ZL) | b(PCE) | b(RD) | b(MDR_RAM) | b(MDR));
    q.push_back(b(MDRO) | b(IR));
    if (o == 0 || o == 1 || o == 2) begin
      q.push_back(b(GRB) | b(BA) | b(Y));
      q.push_back(b(CO) | b(Z));
      if (o == 1) q.push_back(b(ZL) | b(GRA) | b(REN));
      else        q.push_back(b(ZL) | b(MAR));
      if (o == 0) begin
        q.push_back(b(RD) | b(MDR_RAM) | b(MDR));
        q.push_back(b(MDRO) | b(GRA) | b(REN));
      end else if (o == 2) begin
        q.push_back(b(GRA) | b(ROUT) | b(MDR_BUS) | b(MDR));
        q.push_back(b(WR));
      end
    end else if (o >= 3 && o <= 13) begin
      q.push_back(b(GRB) | b(ROUT) | b(Y));
      q.push_back((o <= 10) ? (b(GRC) | b(ROUT) | b(Z)) : (b(CO) | b(Z)));
      q.push_back(b(ZL) | b(GRA) | b(REN));
    end else if (o == 14 || o == 15) begin
      q.push_back(b(GRA) | b(ROUT) | b(Y));
      q.push_back(b(GRB) | b(ROUT) | b(Z));
      q.push_back(b(ZL) | b(LO));
      q.push_back(b(ZH) | b(HI));
    end else if (o == 16 || o == 17) begin
      q.push_back(b(GRB) | b(ROUT) | b(Z));
      q.push_back(b(ZL) | b(GRA) | b(REN));
    end else if (o == 18) begin
      q.push_back(b(GRA) | b(ROUT) | b(CON));
      q.push_back(b(PCO) | b(Y));
      q.push_back(b(CO) | b(Z));
      q.push_back(b(ZL) | (con ? b(PCE) : vec_t'(0)));
    end else if (o == 19) q.push_back(b(GRA) | b(ROUT) | b(PCE));
    else if (o == 20) begin
      q.push_back(b(PCO) | b(RIN15));
      q.push_back(b(GRA) | b(ROUT) | b(PCE));
    end
    else if (o == 21) q.push_back(b(INO) | b(GRA) | b(REN));
    else if (o == 22) q.push_back(b(GRA) | b(ROUT) | b(OUTP));
    else if (o == 23) q.push_back(b(HIO) | b(GRA) | b(REN));
    else if (o == 24) q.push_back(b(LOO) | b(GRA) | b(REN));
    else if (o != 26) q.push_back(vec_t'(0));   // nop and unused opcodes
  endtask

  // Drives one instruction from T0, checking every T-state; entered at a negedge.
  task automatic run_instr(logic [4:0] op, logic con, int stop_at, int abort_at,
                           output logic halted, output logic aborted);
    build_q(op, con);
    halted  = 1'b0;
    aborted = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      if (i == abort_at) begin
        aborted = 1'b1;
        return;
      end
      opcode  = (i < 3) ? op : 5'($urandom);
      CON_out = con;
      Stop    = (i >= stop_at);
      #1;
      chk($sformatf("op%0d_T%0d", op, i), obs, q[i]);
      chk($sformatf("op%0d_T%0d_run", op, i), {45'd0, Run}, vec_t'(1));
      @(negedge clk);
    end
    halted = (op == 5'd26) || (stop_at < q.size());
  endtask

  task automatic check_halt(int n);
    for (int i = 0; i < n; i++) begin
      opcode  = 5'($urandom);
      Stop    = 1'($urandom);
      CON_out = 1'($urandom);
      #1;
      chk("halt_strobes", obs, vec_t'(0));
      chk("halt_run", {45'd0, Run}, vec_t'(0));
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    clr  = 1'b1;
    Stop = 1'b0;
    #1;
    chk("rst_strobes", obs, vec_t'(0));
    chk("rst_run", {45'd0, Run}, vec_t'(1));
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    logic h, a;
    logic [4:0] rop;
    int sa, ab;
    @(negedge clk);
    do_reset();

    // Directed: add, branch not-taken/taken, store.
    run_instr(5'd3,  1'b0, 99, 99, h, a);
    run_instr(5'd18, 1'b0, 99, 99, h, a);
    run_instr(5'd18, 1'b1, 99, 99, h, a);
    run_instr(5'd2,  1'b0, 99, 99, h, a);
    run_instr(5'd20, 1'b0, 99, 99, h, a);
    run_instr(5'd31, 1'b0, 99, 99, h, a);

    // Stop raised during T4 of mul: instruction finishes, then halt.
    run_instr(5'd14, 1'b0, 4, 99, h, a);
    chk("mul_stop_halted", {45'd0, h}, vec_t'(1));
    check_halt(10);
    do_reset();

    // halt opcode.
    run_instr(5'd26, 1'b0, 99, 99, h, a);
    check_halt(10);
    do_reset();

    // clr in the middle of ld.
    run_instr(5'd0, 1'b0, 99, 5, h, a);
    do_reset();
    run_instr(5'd0, 1'b0, 99, 99, h, a);

    // Random instruction stream.
    for (int k = 0; k < 80; k++) begin
      rop = 5'($urandom);
      sa  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : 99;
      ab  = ($urandom_range(0, 11) == 0) ? int'($urandom_range(1, 6)) : 99;
      run_instr(rop, 1'($urandom), sa, ab, h, a);
      if (a) do_reset();
      else if (h) begin
        check_halt(3);
        do_reset();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
